// File: rtl/i2c_eeprom_target_if.sv
// I2C pad bundle for the EEPROM-emulating target: raw SCL/SDA levels in,
// open-drain SDA pull-down enable out.
interface i2c_eeprom_target_if;
   logic i_scl;
   logic i_sda;
   logic o_sda_oe;

   modport slave  (input i_scl, input i_sda, output o_sda_oe);
   modport master (output i_scl, output i_sda, input o_sda_oe);
endinterface

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 16-bit-addressed serial EEPROM.
// SCL/SDA are synchronized and glitch-filtered, then decoded into
// START/STOP/edge events that drive a byte-level FSM.
// Optional write protect input is enabled by defining I2C_TGT_WP_EN.
module i2c_eeprom_target #(
   parameter int DEPTH_LOG2 = 10,
   parameter int PAGE_LOG2  = 5,
   parameter int FILT_LEN   = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [6:0]            i_dev_addr,
   i2c_eeprom_target_if.slave    bus,
`ifdef I2C_TGT_WP_EN
   input  logic                  i_wp,
`endif
   output logic                  o_busy,
   output logic                  o_wr_strobe,
   output logic [15:0]           o_wr_addr,
   output logic [7:0]            o_wr_data,
   output logic [15:0]           o_ptr,
   input  logic [DEPTH_LOG2-1:0] i_bd_addr,
   output logic [7:0]            o_bd_data
);

   typedef enum logic [3:0] {
      S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_PTR_H, S_PTR_H_ACK, S_PTR_L,
      S_PTR_L_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
   } state_t;

   localparam logic [2:0] FILT_MAX = 3'(FILT_LEN - 1);

   // bit 0 = SCL, bit 1 = SDA
   logic [1:0]      r_s1, r_s2, r_flt, r_flt_q;
   logic [1:0][2:0] r_cnt;

   state_t          r_state;
   logic [2:0]      r_bitcnt;
   logic [7:0]      r_shift, r_ptr_h;
   logic [15:0]     r_ptr;
   logic            r_rw, r_ack_on, r_rd_load, r_sda_oe, r_busy;
   logic            r_wr_strobe;
   logic [15:0]     r_wr_addr;
   logic [7:0]      r_wr_data;
   logic [7:0]      r_bd_data;
   logic [7:0]      r_mem [0:(1<<DEPTH_LOG2)-1];

   logic            w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_wp;
   logic [7:0]      w_byte;
   logic [15:0]     w_ptr_pg, w_ptr_rd;

`ifdef I2C_TGT_WP_EN
   assign w_wp = i_wp;
`else
   assign w_wp = 1'b0;
`endif

   // 2-flop synchronizer plus a run-length filter per line; idle bus is high
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1    <= '1;
         r_s2    <= '1;
         r_flt   <= '1;
         r_flt_q <= '1;
         r_cnt   <= '0;
      end else begin
         r_s1    <= {bus.i_sda, bus.i_scl};
         r_s2    <= r_s1;
         r_flt_q <= r_flt;
         for (int k = 0; k < 2; k++) begin
            if (r_s2[k] != r_flt[k]) begin
               if (r_cnt[k] == FILT_MAX) begin
                  r_flt[k] <= r_s2[k];
                  r_cnt[k] <= '0;
               end else begin
                  r_cnt[k] <= r_cnt[k] + 3'd1;
               end
            end else begin
               r_cnt[k] <= '0;
            end
         end
      end
   end

   assign w_scl_rise = r_flt[0] & ~r_flt_q[0];
   assign w_scl_fall = ~r_flt[0] & r_flt_q[0];
   assign w_start    = r_flt[0] & r_flt_q[0] & ~r_flt[1] & r_flt_q[1];
   assign w_stop     = r_flt[0] & r_flt_q[0] & r_flt[1] & ~r_flt_q[1];
   assign w_byte     = {r_shift[6:0], r_flt[1]};
   assign w_last     = (r_bitcnt == 3'd7);
   // writes roll over inside the page, reads roll over the whole array
   assign w_ptr_pg   = {r_ptr[15:PAGE_LOG2], r_ptr[PAGE_LOG2-1:0] + PAGE_LOG2'(1)};
   assign w_ptr_rd   = {r_ptr[15:DEPTH_LOG2], r_ptr[DEPTH_LOG2-1:0] + DEPTH_LOG2'(1)};

   // Protocol FSM: bits sampled on SCL rise, SDA driven only after SCL fall
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_ptr_h     <= '0;
         r_ptr       <= '0;
         r_rw        <= 1'b0;
         r_ack_on    <= 1'b0;
         r_rd_load   <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
      end else begin
         r_wr_strobe <= 1'b0;
         if (r_wr_strobe) r_ptr <= w_ptr_pg;
         // read byte fetched the cycle after the triggering event
         if (r_rd_load) begin
            r_shift   <= r_mem[r_ptr[DEPTH_LOG2-1:0]];
            r_rd_load <= 1'b0;
         end
         if (w_start) begin
            r_state  <= S_DEV_ADDR;
            r_bitcnt <= '0;
            r_sda_oe <= 1'b0;
            r_ack_on <= 1'b0;
         end else if (w_stop) begin
            r_state  <= S_IDLE;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_ack_on <= 1'b0;
         end else begin
            case (r_state)
               S_DEV_ADDR, S_PTR_H, S_PTR_L, S_WR_DATA: if (w_scl_rise) begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (w_last) begin
                     case (r_state)
                        S_DEV_ADDR: begin
                           if (w_byte[7:1] == i_dev_addr) begin
                              r_state   <= S_DEV_ACK;
                              r_rw      <= w_byte[0];
                              r_rd_load <= w_byte[0];
                              r_busy    <= 1'b1;
                           end else begin
                              r_state <= S_WAIT_STOP;
                              r_busy  <= 1'b0;
                           end
                        end
                        S_PTR_H: begin
                           r_ptr_h <= w_byte;
                           r_state <= S_PTR_H_ACK;
                        end
                        S_PTR_L: begin
                           r_ptr   <= {r_ptr_h, w_byte};
                           r_state <= S_PTR_L_ACK;
                        end
                        default: begin
                           if (w_wp) begin
                              r_state <= S_WAIT_STOP;
                              r_busy  <= 1'b0;
                           end else begin
                              r_wr_strobe <= 1'b1;
                              r_wr_addr   <= r_ptr;
                              r_wr_data   <= w_byte;
                              r_state     <= S_WR_ACK;
                           end
                        end
                     endcase
                  end
               end
               // ACK slot spans one fall to the next fall
               S_DEV_ACK, S_PTR_H_ACK, S_PTR_L_ACK, S_WR_ACK: if (w_scl_fall) begin
                  if (!r_ack_on) begin
                     r_sda_oe <= 1'b1;
                     r_ack_on <= 1'b1;
                  end else begin
                     r_ack_on <= 1'b0;
                     r_bitcnt <= '0;
                     r_sda_oe <= 1'b0;
                     case (r_state)
                        S_DEV_ACK: begin
                           if (r_rw) begin
                              r_state  <= S_RD_DATA;
                              r_sda_oe <= ~r_shift[7];
                           end else begin
                              r_state <= S_PTR_H;
                           end
                        end
                        S_PTR_H_ACK: r_state <= S_PTR_L;
                        default:     r_state <= S_WR_DATA;
                     endcase
                  end
               end
               S_RD_DATA: begin
                  if (w_scl_fall) begin
                     r_sda_oe <= ~r_shift[3'd7 - r_bitcnt];
                  end else if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (w_last) r_state <= S_RD_ACK;
                  end
               end
               // pointer advances past every byte sent; only an ACK fetches more
               S_RD_ACK: begin
                  if (w_scl_fall) begin
                     r_sda_oe <= 1'b0;
                  end else if (w_scl_rise) begin
                     r_ptr <= w_ptr_rd;
                     if (!r_flt[1]) begin
                        r_state   <= S_RD_DATA;
                        r_bitcnt  <= '0;
                        r_rd_load <= 1'b1;
                     end else begin
                        r_state <= S_WAIT_STOP;
                        r_busy  <= 1'b0;
                     end
                  end
               end
               default: r_sda_oe <= 1'b0;
            endcase
         end
      end
   end

   // Memory array, contents survive reset
   always_ff @(posedge i_clk) begin
      if (r_wr_strobe) r_mem[r_wr_addr[DEPTH_LOG2-1:0]] <= r_wr_data;
   end

   // Backdoor read port; a same-cycle bus write returns the old byte
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_bd_data <= '0;
      else          r_bd_data <= r_mem[i_bd_addr];
   end

   assign bus.o_sda_oe = r_sda_oe;
   assign o_busy       = r_busy;
   assign o_wr_strobe  = r_wr_strobe;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = r_wr_data;
   assign o_ptr        = r_ptr;
   assign o_bd_data    = r_bd_data;

endmodule

// File: doc/i2c_eeprom_target.md
# i2c_eeprom_target

- I2C target (responder) that emulates a 16-bit-addressed serial EEPROM: an internal byte array reached through a pointer.
- Serves the bus transactions issued by the team's EEPROM controller: pointer write, data write, current-address read and random read.
- Use cases: board-level emulation of the calibration EEPROM, and loop-back verification of the controller.
- Fully synchronous to i_clk; SCL/SDA are oversampled, and SDA is driven open-drain through an output-enable.

## Interface
- DEPTH_LOG2, 10: memory size is 2^DEPTH_LOG2 bytes; pointer bits above this are stored but ignored for addressing.
- PAGE_LOG2, 5: write page size is 2^PAGE_LOG2 bytes.
- FILT_LEN, 3: number of consecutive equal synchronized samples needed to accept a new SCL/SDA level (1..7).
- i_clk  in  1  system clock, 100 MHz; requires f_clk ≥ 40 × f_SCL.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_dev_addr  in  7  target address.
- i_scl  in  1  bus SCL, raw pad level.
- i_sda  in  1  bus SDA, raw pad level.
- o_sda_oe  out  1  1 = pull SDA low; 0 = release. The top level builds the open-drain buffer.
- i_wp  in  1  write protect; present only with I2C_TGT_WP_EN.
- o_busy  out  1  1 from accepted address ACK until STOP/NACK exit.
- o_wr_strobe  out  1  one-cycle pulse per byte written to memory.
- o_wr_addr  out  16  pointer value used by that write.
- o_wr_data  out  8  byte written.
- o_ptr  out  16  current pointer.
- i_bd_addr  in  DEPTH_LOG2  backdoor read address.
- o_bd_data  out  8  mem[i_bd_addr], registered, 1-cycle latency.

## Operation
- Input conditioning: 2-flop synchronizer, then filter; filtered levels are scl_f/sda_f.
- Edge events are derived from filtered levels only:
  - scl_rise, scl_fall.
  - START = sda_f fall while scl_f=1.
  - STOP = sda_f rise while scl_f=1.
- START or STOP in any state has priority over bit events.
  - START (including repeated START) → DEV_ADDR, bit count 0, o_sda_oe=0.
  - STOP → IDLE, o_sda_oe=0, o_busy=0.
- Bits are sampled on scl_rise, MSB first. SDA is changed only on scl_fall.
- States: IDLE, DEV_ADDR, DEV_ACK, PTR_H, PTR_H_ACK, PTR_L, PTR_L_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- DEV_ADDR: after 8 bits, compare [7:1] with i_dev_addr.
  - Match → DEV_ACK: drive oe=1 from the next scl_fall to the following scl_fall.
  - Mismatch → WAIT_STOP, no ACK.
- R/W=0: → PTR_H → ACK → PTR_L → ACK → WR_DATA.
  - Pointer is committed {H,L} at PTR_L's 8th rising edge.
- WR_DATA: byte complete → write mem[ptr], pulse o_wr_strobe, ACK.
  - Pointer increment wraps within the page: ptr[PAGE_LOG2-1:0]+1, upper bits unchanged.
  - Writing more than one page of bytes overwrites the start of the page.
- R/W=1 (current-address read): load mem[ptr] into shifter at DEV_ACK, then RD_DATA.
  - Bit 7 is driven at the scl_fall that ends the ACK.
  - oe = ~bit, updated at each scl_fall.
- After 8 bits, release SDA (RD_ACK) and sample the controller's ACK on scl_rise.
  - 0 → ptr+1, wrapping modulo 2^DEPTH_LOG2; load the next byte; RD_DATA.
  - 1 → WAIT_STOP.
- Random read = pointer write followed by repeated START or STOP/START, then read.
- WAIT_STOP: SDA released; leaves only on START/STOP.
- ptr persists across transactions and is not cleared by STOP.

## Timing
- Reset values:
  - o_sda_oe=0, o_busy=0, o_wr_strobe=0, o_wr_addr=0, o_wr_data=0, o_ptr=0, o_bd_data=0, state IDLE.
  - Memory contents are not reset.
- Event latency: 2 + FILT_LEN i_clk from pad change to event. Pulses narrower than FILT_LEN cycles are rejected.
- SDA output change: 1 cycle after scl_fall event. This gives ≥ FILT_LEN+3 i_clk hold after the pad falls.
- o_wr_strobe is asserted 1 cycle after the 8th scl_rise of a data byte. o_wr_addr/o_wr_data are valid in the same cycle, and o_ptr updates the next cycle.
- Read-byte load: mem read 1 cycle after the triggering event, ready well before the next scl_fall.
- Reset mid-transaction: immediate release of SDA; bus resynchronizes at the next START.
- Simultaneous backdoor read and bus write to the same address: o_bd_data returns the old value.

## Configuration
- I2C_TGT_WP_EN defined: port i_wp exists.
  - While i_wp=1 at a data byte's 8th scl_rise, that byte is NACKed: no write, no strobe, pointer unchanged, → WAIT_STOP.
  - Device address and pointer bytes are still ACKed.
- Not defined: no i_wp port; all data bytes are written and ACKed.

## Test plan
- Write {0x50,0x0012} then bytes A1 B2 C3 D4, STOP → 4 strobes at addr 0x0012..0x0015; backdoor reads A1 B2 C3 D4; o_ptr=0x0016.
- Random read: pointer 0x0012, repeated START, addr 0x50 R; ACK 3 bytes, NACK the 4th → SDA returns A1 B2 C3 D4; state WAIT_STOP; o_ptr=0x0016.
- Page wrap: pointer 0x001E, write 4 bytes 11 22 33 44 → stored at 0x1E, 0x1F, 0x00, 0x01.
- Read wrap: pointer 0x03FF, read 2 bytes with ACK then NACK → mem[0x3FF], then mem[0x000].
- Address mismatch: address 0x51 with i_dev_addr=0x50 → o_sda_oe stays 0 for the whole transaction; no strobes.
- Glitch and abort:
  - 2-cycle SCL glitch mid-byte → ignored; the byte is received correctly.
  - STOP after 4 data bits → IDLE, no write.
  - With I2C_TGT_WP_EN and i_wp=1: first data byte NACKed, memory unchanged.
